// File: rtl/word_tx_fifo.sv
// word_tx_fifo
//
// Transmit FIFO plus word-to-byte serializer that sits between the core's
// output-word producer and the byte-wide UART transmitter.
//
// Words are queued in a DEPTH-entry memory. A one-word serializer pulls
// them out and emits them as NBYTES bytes, most or least significant
// byte first. When the last byte of a word is taken and another word is
// waiting, that word is loaded on the same edge. Consecutive words
// therefore form one continuous byte stream.
//
// Parameters:
//   WORD_WIDTH - input word width in bits, multiple of 8, 8..64
//   DEPTH      - FIFO depth in words, power of 2, >= 2
//   MSB_FIRST  - 1: most significant byte first, 0: least significant first
//
// Ports:
//   CLK        clock
//   reset      synchronous, active-high
//   in_data    word to enqueue
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept (== !full)
//   out_data   byte to transmitter (0 while no byte is offered)
//   out_valid  out_data valid
//   out_ready  transmitter accepts byte
//   count      words held in FIFO memory (excludes word in serializer)
//   full       count == DEPTH
//   empty      count == 0
//   busy       serializer holds a word
//   overflow   sticky: in_valid was seen while full

module word_tx_fifo #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [WORD_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       busy,
  output logic                       overflow
);

  localparam int NBYTES = WORD_WIDTH / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // ---------------------------------------------------------------------
  // Stage p0: word storage (memory, pointers, occupancy)
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem_p0 [DEPTH];
  logic [AW-1:0]         head_p0;
  logic [AW-1:0]         tail_p0;
  logic [CW-1:0]         count_p0;
  logic                  overflow_p0;

  // ---------------------------------------------------------------------
  // Stage p1: serializer (shift register, byte index, state)
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] shift_p1;
  logic [IW-1:0]         byte_idx_p1;
  logic [0:0]            state_p1;
  logic                  vld_p1;

  logic                  full_p0;
  logic                  empty_p0;
  logic                  push;
  logic                  xfer;
  logic                  last_xfer;
  logic                  load;
  logic [7:0]            cur_byte;

  // Status is derived from registered state only, so there is no
  // combinational path from out_ready to in_ready or from in_valid to
  // out_valid.
  assign full_p0  = (count_p0 == CW'(DEPTH));
  assign empty_p0 = (count_p0 == '0);
  assign vld_p1   = (state_p1 == ST_SEND);

  assign push      = in_valid && !full_p0;
  assign xfer      = vld_p1 && out_ready;
  assign last_xfer = xfer && (byte_idx_p1 == IW'(NBYTES - 1));
  // A word leaves memory either when the serializer is idle or on the
  // same edge that the final byte of the current word is accepted.
  assign load      = !empty_p0 && (!vld_p1 || last_xfer);

  // Memory contents are plain data and carry no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_p0[tail_p0] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head_p0     <= '0;
      tail_p0     <= '0;
      count_p0    <= '0;
      overflow_p0 <= 1'b0;
    end else begin
      if (push) begin
        tail_p0 <= tail_p0 + AW'(1);
      end
      if (load) begin
        head_p0 <= head_p0 + AW'(1);
      end
      case ({push, load})
        2'b10:   count_p0 <= count_p0 + CW'(1);
        2'b01:   count_p0 <= count_p0 - CW'(1);
        default: count_p0 <= count_p0;
      endcase
      if (in_valid && full_p0) begin
        overflow_p0 <= 1'b1;
      end
    end
  end

  // The shift register holds data only. Its contents are invisible while
  // the serializer is idle because out_data is forced to zero then.
  always_ff @(posedge CLK) begin
    if (load) begin
      shift_p1 <= mem_p0[head_p0];
    end else if (xfer) begin
      if (MSB_FIRST) begin
        shift_p1 <= shift_p1 << 8;
      end else begin
        shift_p1 <= shift_p1 >> 8;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_p1    <= ST_IDLE;
      byte_idx_p1 <= '0;
    end else begin
      if (load) begin
        state_p1    <= ST_SEND;
        byte_idx_p1 <= '0;
      end else begin
        if (last_xfer) begin
          state_p1 <= ST_IDLE;
        end
        if (xfer) begin
          byte_idx_p1 <= byte_idx_p1 + IW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cur_byte  = MSB_FIRST ? shift_p1[WORD_WIDTH-1 -: 8] : shift_p1[7:0];
  assign out_data  = vld_p1 ? cur_byte : 8'h00;
  assign out_valid = vld_p1;
  assign busy      = vld_p1;
  assign in_ready  = !full_p0;
  assign count     = count_p0;
  assign full      = full_p0;
  assign empty     = empty_p0;
  assign overflow  = overflow_p0;

endmodule

// File: tb/tb_word_tx_fifo.sv
// Directed bench for word_tx_fifo.
// Instance a: 32-bit words, DEPTH=4, MSB first.
// Instance b: 32-bit words, DEPTH=4, LSB first.
module tb_word_tx_fifo;

  logic        CLK = 1'b0;
  logic        reset;

  logic [31:0] a_in_data, b_in_data;
  logic        a_in_valid, b_in_valid, a_in_ready, b_in_ready;
  logic [7:0]  a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid, a_out_ready, b_out_ready;
  logic [2:0]  a_count, b_count;
  logic        a_full, b_full, a_empty, b_empty;
  logic        a_busy, b_busy, a_overflow, b_overflow;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  word_tx_fifo #(.WORD_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1)) u_a (
    .CLK(CLK), .reset(reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .count(a_count), .full(a_full), .empty(a_empty), .busy(a_busy),
    .overflow(a_overflow)
  );

  word_tx_fifo #(.WORD_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0)) u_b (
    .CLK(CLK), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .count(b_count), .full(b_full), .empty(b_empty), .busy(b_busy),
    .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  // Producer/consumer run on instance a with a byte scoreboard.
  // mode 0: out_ready pattern 1,0,0,1 and in_valid held; mode 1: random gaps.
  task automatic run_stream(input int nwords, input int mode);
    logic [31:0] words[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  hold_data;
    logic [7:0]  want;
    bit          hold;
    int          sent;
    int          cyc;
    sent = 0;
    cyc = 0;
    hold = 1'b0;
    hold_data = 8'h00;
    for (int i = 0; i < nwords; i++) words.push_back($urandom);
    while ((sent < nwords || exp_q.size() != 0) && cyc < 3000) begin
      if (mode == 0) a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else           a_out_ready = ($urandom_range(0, 2) != 0);
      if (sent < nwords && (mode == 0 || $urandom_range(0, 1) == 1)) begin
        a_in_valid = 1'b1;
        a_in_data  = words[sent];
      end else begin
        a_in_valid = 1'b0;
      end
      if (hold) begin
        check("hold_valid", {31'd0, a_out_valid}, 32'd1);
        check("hold_data", {24'd0, a_out_data}, {24'd0, hold_data});
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", {31'd0, a_out_valid}, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check("stream_byte", {24'd0, a_out_data}, {24'd0, want});
        end
      end
      hold      = a_out_valid && !a_out_ready;
      hold_data = a_out_data;
      if (a_in_valid && a_in_ready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(byte_of(words[sent], k));
        sent++;
      end
      step();
      cyc++;
    end
    check("stream_words_sent", sent, nwords);
    check("stream_drained", exp_q.size(), 0);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    step();
  endtask

  logic [31:0] fw [6];
  logic [31:0] rw [4];
  logic [7:0]  lsb_exp [8];
  logic [7:0]  msb_exp [4];
  int k;

  initial begin
    fw = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243, 32'h50515253, 32'h60616263};
    rw = '{32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB, 32'hCCCDCECF};
    lsb_exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    msb_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    reset = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_out_data", {24'd0, a_out_data}, 32'd0);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_count", {29'd0, a_count}, 32'd0);
    check("rst_empty", {31'd0, a_empty}, 32'd1);
    check("rst_full", {31'd0, a_full}, 32'd0);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_overflow", {31'd0, a_overflow}, 32'd0);
    check("rst_b_empty", {31'd0, b_empty}, 32'd1);

    // Single word, MSB first
    a_in_valid = 1'b1; a_in_data = 32'hA1B2C3D4; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("single_lat_valid", {31'd0, a_out_valid}, 32'd0);
    check("single_lat_count", {29'd0, a_count}, 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("single_valid", {31'd0, a_out_valid}, 32'd1);
      check("single_byte", {24'd0, a_out_data}, {24'd0, msb_exp[i]});
      step();
    end
    check("single_end_valid", {31'd0, a_out_valid}, 32'd0);
    check("single_end_empty", {31'd0, a_empty}, 32'd1);
    check("single_end_busy", {31'd0, a_busy}, 32'd0);

    // Two words back-to-back, LSB first
    b_in_valid = 1'b1; b_in_data = 32'h11223344; b_out_ready = 1'b1;
    step();
    b_in_data = 32'h55667788;
    check("lsb_lat_valid", {31'd0, b_out_valid}, 32'd0);
    step();
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_valid", {31'd0, b_out_valid}, 32'd1);
      check("lsb_byte", {24'd0, b_out_data}, {24'd0, lsb_exp[i]});
      step();
    end
    check("lsb_end_valid", {31'd0, b_out_valid}, 32'd0);
    check("lsb_end_empty", {31'd0, b_empty}, 32'd1);
    b_out_ready = 1'b0;

    // Backpressure with 1,0,0,1 pattern, 16 random words
    run_stream(16, 0);
    // Wrap-around with random gaps, 20 words
    run_stream(20, 1);

    // Fill with out_ready low
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("fill_pre_overflow", {31'd0, a_overflow}, 32'd0);
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = fw[i];
      step();
    end
    check("fill_busy", {31'd0, a_busy}, 32'd1);
    check("fill_count", {29'd0, a_count}, 32'd4);
    check("fill_full", {31'd0, a_full}, 32'd1);
    check("fill_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("fill_overflow_before", {31'd0, a_overflow}, 32'd0);
    check("fill_head_byte", {24'd0, a_out_data}, 32'h10);
    a_in_data = fw[5];
    step();
    a_in_valid = 1'b0;
    check("fill_overflow_after", {31'd0, a_overflow}, 32'd1);
    check("fill_count_after", {29'd0, a_count}, 32'd4);
    check("fill_hold_byte", {24'd0, a_out_data}, 32'h10);
    k = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_out_ready = 1'b1;
      if (a_out_valid) begin
        if (k < 20) check("fill_byte", {24'd0, a_out_data}, {24'd0, byte_of(fw[k / 4], k % 4)});
        else        check("fill_extra", {31'd0, a_out_valid}, 32'd0);
        k++;
      end
      step();
    end
    check("fill_byte_total", k, 20);
    check("fill_drain_empty", {31'd0, a_empty}, 32'd1);

    // Reset mid-word with 3 words queued (overflow still set from fill)
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_data = rw[i];
      step();
    end
    a_in_valid = 1'b0;
    check("midrst_count", {29'd0, a_count}, 32'd3);
    check("midrst_overflow_set", {31'd0, a_overflow}, 32'd1);
    a_out_ready = 1'b1;
    check("midrst_byte0", {24'd0, a_out_data}, 32'hC0);
    step();
    check("midrst_byte1", {24'd0, a_out_data}, 32'hC1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, a_out_data}, 32'd0);
    check("midrst_count0", {29'd0, a_count}, 32'd0);
    check("midrst_empty", {31'd0, a_empty}, 32'd1);
    check("midrst_overflow", {31'd0, a_overflow}, 32'd0);
    check("midrst_busy", {31'd0, a_busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("midrst_quiet", {31'd0, a_out_valid}, 32'd0);
      step();
    end
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF;
    step();
    a_in_valid = 1'b0;
    step();
    check("post_rst_b0", {24'd0, a_out_data}, 32'hDE);
    step();
    check("post_rst_b1", {24'd0, a_out_data}, 32'hAD);
    step();
    check("post_rst_b2", {24'd0, a_out_data}, 32'hBE);
    step();
    check("post_rst_b3", {24'd0, a_out_data}, 32'hEF);
    step();
    check("post_rst_idle", {31'd0, a_out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_tx_fifo.md
# word_tx_fifo

Parametrised transmit FIFO and word-to-byte serializer between the core's output-word producer and the byte-wide UART transmitter. It generalises the fixed 32-bit, 32-entry sender buffer:
- word width, depth and byte order are parameters;
- both sides use a full valid/ready handshake;
- full, empty, occupancy and a sticky overflow flag are exposed.

Back-to-back words stream with no idle cycle between bytes.

## Interface
- WORD_WIDTH, 32, input word width in bits; multiple of 8, 8..64; NBYTES = WORD_WIDTH/8
- DEPTH, 32, FIFO depth in words; power of 2, >= 2
- MSB_FIRST, 1, 1: most significant byte sent first; 0: least significant byte first

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  WORD_WIDTH  word to enqueue
- in_valid  in  1  producer offers in_data
- in_ready  out  1  FIFO can accept; equals !full
- out_data  out  8  byte to transmitter
- out_valid  out  1  out_data valid
- out_ready  in  1  transmitter accepts byte
- count  out  $clog2(DEPTH)+1  words stored in FIFO memory (excludes word in serializer)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  serializer holds a word
- overflow  out  1  sticky; in_valid seen while full

## Operation
- Storage: DEPTH x WORD_WIDTH array, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, separate count register. No head==tail ambiguity.
- Push: in_valid && in_ready at a rising edge writes mem[tail], tail+1, count+1.
- Push while full: word dropped, overflow set to 1 until reset; no pointer change.
- Serializer FSM:
  - IDLE: busy=0, out_valid=0. If count>0, load mem[head] into shift register, head+1, count-1, byte index=0, go to SEND.
  - SEND: busy=1, out_valid=1, out_data = current byte:
    - MSB_FIRST=1: bits [WORD_WIDTH-1 -: 8], shift left 8 per transfer.
    - MSB_FIRST=0: bits [7:0], shift right 8 per transfer.
  - On out_valid && out_ready, the byte index increments.
  - On the transfer of byte NBYTES-1: if count>0, load the next word on the same edge and stay in SEND (no bubble); else go to IDLE.
- out_data/out_valid are stable while out_valid && !out_ready (AXI-stream rule).
- Simultaneous push and load in one cycle: count unchanged, both pointers advance.
- Push into an empty FIFO while IDLE: word lands in memory, loaded on the next edge.
- Reset mid-operation: queued words and any partially sent word are discarded; no further bytes emitted.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, count=0, empty=1, full=0, in_ready=1, overflow=0. Memory contents need not be cleared.
- Latency, FIFO empty and serializer IDLE: word accepted at edge E, first byte valid (out_valid=1) from edge E+1.
- Word throughput: NBYTES cycles per word with out_ready held high.
- Byte stream: continuous, with out_valid never dropping between consecutive words while count>0.
- count/full/empty/in_ready are registered-state derived. in_ready falls in the cycle after the push that fills the FIFO and rises the cycle after the load that frees a slot.
- Capacity: DEPTH words in memory plus 1 word in the serializer.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Test plan
- Single word, WORD_WIDTH=32, MSB_FIRST=1, push 0xA1B2C3D4 with out_ready=1: bytes A1,B2,C3,D4 on 4 consecutive cycles starting E+1. Then out_valid=0, empty=1.
- MSB_FIRST=0, push 0x11223344 then 0x55667788 back-to-back: byte stream 44,33,22,11,88,77,66,55 with out_valid high for 8 contiguous cycles.
- Backpressure: out_ready toggled 1,0,0,1,...: each byte held stable while out_ready=0; none skipped or duplicated over 16 random words checked against a scoreboard.
- Fill, DEPTH=4, out_ready=0: push 6 words. Result: 1 word in the serializer, count=4, full=1, in_ready=0; 6th word dropped, overflow=1. Release out_ready: exactly 5 words delivered in order.
- Wrap-around, DEPTH=4: stream 20 words with random in_valid/out_ready gaps; output order matches input across pointer wrap.
- Reset during byte 2 of a word with 3 words queued: next cycle out_valid=0, count=0, empty=1, overflow=0; a subsequent push is delivered correctly.
